mem_bus_arbiter: RTL and testbench

- Shares the single tagged memory bus between the data cache (requester 0) and the instruction cache (requester 1).
- Each cycle it grants at most one request and forwards it to memory.
- It records which requester owns each accepted load tag, and steers each returning tag back to that owner.
- It sits between the two cache controllers and the memory model / main-memory interface.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_tag_owner_table.sv | 56 +++++
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the cache/memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_bus_arbiter_pkg;

  // Bus command encoding shared by both caches and the memory side.
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  // Requester identity, stored per tag in the owner table.
  typedef enum logic {
    REQ_DCACHE = 1'b0,
    REQ_ICACHE = 1'b1
  } req_id_t;

  localparam int MEM_TAG_W         = 4;
  localparam int NUM_MEM_TAGS      = 2 ** MEM_TAG_W;
  localparam int DCACHE_BLOCK_SIZE = 64;

  // A command asks for the bus whenever it is not BUS_NONE.
  function automatic logic is_request(input BUS_COMMAND cmd);
    return cmd != BUS_NONE;
  endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Per-tag {valid, owner} table recording which cache owns each outstanding load.
// Latency: lookups are combinational; set/clear take effect at the next clock edge.
// Backpressure: none; a set and a clear of the same tag in one cycle resolve to the set.
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset (clears all entries)
//   set_en/tag/owner    record a newly accepted load
//   set_valid           current valid bit of the entry addressed by set_tag
//   clr_en/clr_tag      release an entry whose data has returned
//   lookup_tag          tag to look up; lookup_valid/lookup_owner give the entry
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_W = MEM_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  req_id_t          set_owner,
  output logic             set_valid,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output req_id_t          lookup_owner
);

  localparam int N = 2 ** TAG_W;

  logic [N-1:0] valid_q;
  req_id_t      owner_q [N];

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      for (int k = 0; k < N; k++) begin
        owner_q[k] <= REQ_DCACHE;
      end
    end else begin
      if (clr_en) begin
        valid_q[clr_tag] <= 1'b0;
      end
      // Ordered after the clear so a same-tag reuse keeps the new owner.
      if (set_en) begin
        valid_q[set_tag] <= 1'b1;
        owner_q[set_tag] <= set_owner;
      end
    end
  end

  assign set_valid    = valid_q[set_tag];
  assign lookup_valid = valid_q[lookup_tag];
  assign lookup_owner = owner_q[lookup_tag];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates dcache/icache onto one tagged memory bus and steers returning tags to their owner.
// Latency: request and return paths are combinational (zero cycles); bookkeeping updates at the edge.
// Backpressure: memory refuses with response 0; the granted cache sees 0 and retries, priority holds.
//
// Ports:
//   clock, reset                         system clock, synchronous active-low reset
//   d_cmd/d_addr/d_data, d_response      dcache request and issued tag (0 = refused)
//   i_cmd/i_addr, i_response             icache request and issued tag (0 = refused)
//   d_tag, i_tag                         completing tag per cache (0 = none)
//   arb2mem_command/addr/data            forwarded request
//   mem2arb_response/tag/data_in         memory acceptance tag, completing tag and data
//   mem2arb_data                         returned data broadcast to both caches
//   d_outstanding, i_outstanding         loads in flight per cache
//   tag_err                              sticky protocol-error flag
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = DCACHE_BLOCK_SIZE,
  parameter int TAG_W  = MEM_TAG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  BUS_COMMAND        d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic [TAG_W-1:0]  d_response,
  output logic [TAG_W-1:0]  d_tag,
  input  BUS_COMMAND        i_cmd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [TAG_W-1:0]  i_response,
  output logic [TAG_W-1:0]  i_tag,
  output logic [DATA_W-1:0] mem2arb_data,
  output BUS_COMMAND        arb2mem_command,
  output logic [ADDR_W-1:0] arb2mem_addr,
  output logic [DATA_W-1:0] arb2mem_data,
  input  logic [TAG_W-1:0]  mem2arb_response,
  input  logic [TAG_W-1:0]  mem2arb_tag,
  input  logic [DATA_W-1:0] mem2arb_data_in,
  output logic [TAG_W:0]    d_outstanding,
  output logic [TAG_W:0]    i_outstanding,
  output logic              tag_err
);

  localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(2 ** TAG_W - 1);

  req_id_t        prio_q;
  logic [TAG_W:0] d_cnt_q;
  logic [TAG_W:0] i_cnt_q;
  logic           tag_err_q;

  logic    d_req;
  logic    i_req;
  logic    i_store;
  logic    grant_vld;
  req_id_t grant_id;
  logic    accept;
  logic    load_accept;

  logic    ret_vld;
  logic    ret_hit;
  logic    lookup_valid;
  req_id_t lookup_owner;
  logic    set_valid;
  logic    same_tag_release;
  logic    err_set;

  logic    d_inc, d_dec, i_inc, i_dec;

  // An icache store is illegal: it never competes for the bus.
  assign d_req   = is_request(d_cmd);
  assign i_store = (i_cmd == BUS_STORE);
  assign i_req   = (i_cmd == BUS_LOAD);

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = REQ_DCACHE;
    if (d_req && i_req) begin
      grant_vld = 1'b1;
      grant_id  = prio_q;
    end else if (d_req) begin
      grant_vld = 1'b1;
      grant_id  = REQ_DCACHE;
    end else if (i_req) begin
      grant_vld = 1'b1;
      grant_id  = REQ_ICACHE;
    end
  end

  assign accept      = grant_vld && (mem2arb_response != '0);
  assign load_accept = accept && (arb2mem_command == BUS_LOAD);

  always_comb begin
    arb2mem_command = BUS_NONE;
    arb2mem_addr    = '0;
    arb2mem_data    = '0;
    d_response      = '0;
    i_response      = '0;
    if (grant_vld) begin
      if (grant_id == REQ_DCACHE) begin
        arb2mem_command = d_cmd;
        arb2mem_addr    = d_addr;
        arb2mem_data    = d_data;
        d_response      = mem2arb_response;
      end else begin
        arb2mem_command = i_cmd;
        arb2mem_addr    = i_addr;
        i_response      = mem2arb_response;
      end
    end
  end

  mem_tag_owner_table #(
    .TAG_W (TAG_W)
  ) u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (load_accept),
    .set_tag      (mem2arb_response),
    .set_owner    (grant_id),
    .set_valid    (set_valid),
    .clr_en       (ret_hit),
    .clr_tag      (mem2arb_tag),
    .lookup_tag   (mem2arb_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner)
  );

  // Returns are only steered while out of reset; the table is being wiped otherwise.
  assign ret_vld = (mem2arb_tag != '0);
  assign ret_hit = reset && ret_vld && lookup_valid;

  assign d_tag        = (ret_hit && lookup_owner == REQ_DCACHE) ? mem2arb_tag : '0;
  assign i_tag        = (ret_hit && lookup_owner == REQ_ICACHE) ? mem2arb_tag : '0;
  assign mem2arb_data = mem2arb_data_in;

  // Reusing a tag that is being released this same cycle is legitimate.
  assign same_tag_release = ret_hit && (mem2arb_tag == mem2arb_response);
  assign err_set = (ret_vld && !lookup_valid)
                || (load_accept && set_valid && !same_tag_release)
                || i_store;

  assign d_inc = load_accept && (grant_id == REQ_DCACHE);
  assign i_inc = load_accept && (grant_id == REQ_ICACHE);
  assign d_dec = ret_hit && (lookup_owner == REQ_DCACHE);
  assign i_dec = ret_hit && (lookup_owner == REQ_ICACHE);

  function automatic logic [TAG_W:0] next_cnt(input logic [TAG_W:0] cnt,
                                              input logic inc, input logic dec);
    logic [TAG_W:0] nxt;
    nxt = cnt;
    if (inc && !dec && cnt != CNT_MAX) begin
      nxt = cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      prio_q    <= REQ_DCACHE;
      d_cnt_q   <= '0;
      i_cnt_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      // Priority passes to the loser only once the winner is actually accepted.
      if (accept) begin
        prio_q <= req_id_t'(~grant_id);
      end
      d_cnt_q <= next_cnt(d_cnt_q, d_inc, d_dec);
      i_cnt_q <= next_cnt(i_cnt_q, i_inc, i_dec);
      if (err_set) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  assign d_outstanding = d_cnt_q;
  assign i_outstanding = i_cnt_q;
  assign tag_err       = tag_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Latency: checks combinational outputs 1 time unit after driving, state 1 unit after an edge.
// Backpressure: memory refusal is modelled by driving mem2arb_response = 0.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;

  logic              clock;
  logic              reset;
  BUS_COMMAND        d_cmd;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic [TAG_W-1:0]  d_response;
  logic [TAG_W-1:0]  d_tag;
  BUS_COMMAND        i_cmd;
  logic [ADDR_W-1:0] i_addr;
  logic [TAG_W-1:0]  i_response;
  logic [TAG_W-1:0]  i_tag;
  logic [DATA_W-1:0] mem2arb_data;
  BUS_COMMAND        arb2mem_command;
  logic [ADDR_W-1:0] arb2mem_addr;
  logic [DATA_W-1:0] arb2mem_data;
  logic [TAG_W-1:0]  mem2arb_response;
  logic [TAG_W-1:0]  mem2arb_tag;
  logic [DATA_W-1:0] mem2arb_data_in;
  logic [TAG_W:0]    d_outstanding;
  logic [TAG_W:0]    i_outstanding;
  logic              tag_err;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .d_cmd            (d_cmd),
    .d_addr           (d_addr),
    .d_data           (d_data),
    .d_response       (d_response),
    .d_tag            (d_tag),
    .i_cmd            (i_cmd),
    .i_addr           (i_addr),
    .i_response       (i_response),
    .i_tag            (i_tag),
    .mem2arb_data     (mem2arb_data),
    .arb2mem_command  (arb2mem_command),
    .arb2mem_addr     (arb2mem_addr),
    .arb2mem_data     (arb2mem_data),
    .mem2arb_response (mem2arb_response),
    .mem2arb_tag      (mem2arb_tag),
    .mem2arb_data_in  (mem2arb_data_in),
    .d_outstanding    (d_outstanding),
    .i_outstanding    (i_outstanding),
    .tag_err          (tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    d_cmd            = BUS_NONE;
    d_addr           = '0;
    d_data           = '0;
    i_cmd            = BUS_NONE;
    i_addr           = '0;
    mem2arb_response = '0;
    mem2arb_tag      = '0;
    mem2arb_data_in  = '0;
  endtask

  task automatic reset_pulse();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    tick();

    // Reset state; a return during reset must not be steered.
    mem2arb_tag = 4'd3;
    #1;
    check("rst_d_out",  d_outstanding, 0);
    check("rst_i_out",  i_outstanding, 0);
    check("rst_err",    tag_err, 0);
    check("rst_cmd",    arb2mem_command, BUS_NONE);
    check("rst_d_tag",  d_tag, 0);
    check("rst_i_tag",  i_tag, 0);
    idle();
    reset = 1'b1;
    tick();

    // Lone dcache load accepted with tag 3, returned 5 cycles later.
    d_cmd = BUS_LOAD; d_addr = 64'h1000; mem2arb_response = 4'd3;
    #1;
    check("t1_d_resp", d_response, 3);
    check("t1_i_resp", i_response, 0);
    check("t1_cmd",    arb2mem_command, BUS_LOAD);
    check("t1_addr",   arb2mem_addr, 64'h1000);
    tick();
    idle();
    #1;
    check("t1_d_out1", d_outstanding, 1);
    tick(); tick(); tick(); tick();
    mem2arb_tag = 4'd3; mem2arb_data_in = 64'hDEAD;
    #1;
    check("t1_d_tag", d_tag, 3);
    check("t1_i_tag", i_tag, 0);
    check("t1_data",  mem2arb_data, 64'hDEAD);
    tick();
    idle();
    #1;
    check("t1_d_out0", d_outstanding, 0);

    // Lone icache load (tag 6) hands priority back to the dcache.
    i_cmd = BUS_LOAD; i_addr = 64'h500; mem2arb_response = 4'd6;
    #1;
    check("t1b_i_resp", i_response, 6);
    check("t1b_data0",  arb2mem_data, 0);
    tick();
    idle();
    mem2arb_tag = 4'd6;
    #1;
    check("t1b_i_tag", i_tag, 6);
    check("t1b_d_tag", d_tag, 0);
    tick();
    idle();

    // Both request with prio 0: dcache first, then icache.
    d_cmd = BUS_LOAD; d_addr = 64'h2000; d_data = 64'hAAAA;
    i_cmd = BUS_LOAD; i_addr = 64'h3000; mem2arb_response = 4'd2;
    #1;
    check("t2_d_resp", d_response, 2);
    check("t2_i_resp", i_response, 0);
    check("t2_addr",   arb2mem_addr, 64'h2000);
    tick();
    mem2arb_response = 4'd5;
    #1;
    check("t2_i_resp2", i_response, 5);
    check("t2_d_resp2", d_response, 0);
    check("t2_addr2",   arb2mem_addr, 64'h3000);
    check("t2_idata",   arb2mem_data, 0);
    tick();
    idle();
    #1;
    check("t2_d_out", d_outstanding, 1);
    check("t2_i_out", i_outstanding, 1);
    mem2arb_tag = 4'd2;
    #1;
    check("t2_ret_d", d_tag, 2);
    tick();
    mem2arb_tag = 4'd5;
    #1;
    check("t2_ret_i", i_tag, 5);
    tick();
    idle();

    // Refusals hold priority on the dcache until it is accepted.
    d_cmd = BUS_LOAD; d_addr = 64'h2000;
    i_cmd = BUS_LOAD; i_addr = 64'h3000;
    for (int k = 0; k < 3; k++) begin
      mem2arb_response = 4'd0;
      #1;
      check("t3_hold_addr", arb2mem_addr, 64'h2000);
      check("t3_hold_i",    i_response, 0);
      tick();
    end
    mem2arb_response = 4'd5;
    #1;
    check("t3_d_acc", d_response, 5);
    tick();
    mem2arb_response = 4'd0;
    #1;
    check("t3_i_grant", arb2mem_addr, 64'h3000);
    idle();
    tick();

    // dcache owns tag 4; icache reuses tag 4 the same cycle it returns.
    d_cmd = BUS_LOAD; d_addr = 64'h4000; mem2arb_response = 4'd4;
    #1;
    check("t4_d_resp", d_response, 4);
    tick();
    idle();
    i_cmd = BUS_LOAD; i_addr = 64'h4400; mem2arb_response = 4'd4; mem2arb_tag = 4'd4;
    #1;
    check("t4_d_tag",  d_tag, 4);
    check("t4_i_tag",  i_tag, 0);
    check("t4_i_resp", i_response, 4);
    tick();
    idle();
    #1;
    check("t4_err",   tag_err, 0);
    check("t4_d_out", d_outstanding, 1);
    check("t4_i_out", i_outstanding, 1);
    mem2arb_tag = 4'd4;
    #1;
    check("t4_owner_i", i_tag, 4);
    tick();
    mem2arb_tag = 4'd5;
    #1;
    check("t4_ret5", d_tag, 5);
    tick();
    idle();
    #1;
    check("t4_d_out0", d_outstanding, 0);
    check("t4_i_out0", i_outstanding, 0);

    // Return of an unknown tag: dropped, sticky error.
    mem2arb_tag = 4'd7;
    #1;
    check("t5_d_tag", d_tag, 0);
    check("t5_i_tag", i_tag, 0);
    tick();
    idle();
    #1;
    check("t5_err", tag_err, 1);
    tick();
    check("t5_err_sticky", tag_err, 1);

    // Reset abandons outstanding tags.
    reset_pulse();
    d_cmd = BUS_LOAD; d_addr = 64'h100; mem2arb_response = 4'd1;
    tick();
    mem2arb_response = 4'd2;
    tick();
    idle();
    #1;
    check("t6_d_out2", d_outstanding, 2);
    check("t6_err0",   tag_err, 0);
    reset_pulse();
    #1;
    check("t6_d_out0", d_outstanding, 0);
    mem2arb_tag = 4'd1;
    #1;
    check("t6_dropped", d_tag, 0);
    tick();
    idle();
    #1;
    check("t6_err1",   tag_err, 1);
    check("t6_cnt",    d_outstanding, 0);

    // Illegal icache store.
    reset_pulse();
    i_cmd = BUS_STORE; i_addr = 64'h900; mem2arb_response = 4'd9;
    #1;
    check("t7_cmd",    arb2mem_command, BUS_NONE);
    check("t7_i_resp", i_response, 0);
    tick();
    idle();
    #1;
    check("t7_err", tag_err, 1);

    // Accepting onto a still-valid entry is an error.
    reset_pulse();
    d_cmd = BUS_LOAD; d_addr = 64'h10; mem2arb_response = 4'd3;
    tick();
    #1;
    check("t8_err0", tag_err, 0);
    d_addr = 64'h20;
    tick();
    idle();
    #1;
    check("t8_err1", tag_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
